// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RISC-V funct3 width codes for loads and stores
//   - FSM state enumeration
//   - access_bad(): decides whether a request must be rejected without
//     touching memory (bad width code, misalignment or out-of-range address)
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Rejection rule for a new request. funct3[1:0] encodes the access size
  // for every legal code (00 byte, 01 half, 10 word), so alignment can be
  // judged on those two bits alone once the code itself is known legal.
  function automatic logic access_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo,
    input logic       oor
  );
    logic f3_bad;
    logic mis;
    if (we) begin
      f3_bad = f3[2] | (f3[1:0] == 2'b11);
    end else begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_bad = 1'b0;
        default:                        f3_bad = 1'b1;
      endcase
    end
    case (f3[1:0])
      2'b01:   mis = lo[0];
      2'b10:   mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return f3_bad | mis | oor;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
// Ports:
//   word       in  32  memory word being read
//   lane       in   2  byte offset of the access within the word
//   funct3     in   3  RISC-V width code
//   wdata      in  16  low half of the store data (sb uses [7:0])
//   load_data  out 32  extracted and sign/zero-extended load result
//   store_word out 32  word with the addressed byte/halfword lane replaced
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = word >> {lane, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h000000, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Store path: replace only the addressed lane, keep the rest of the word.
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          2'd3:    store_word[31:24] = wdata[7:0];
          default: store_word        = word;
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          store_word[31:16] = wdata;
        end else begin
          store_word[15:0] = wdata;
        end
      end
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes one RISC-V byte/half/word load or store at a time
// against a word-addressed single-port memory (combinational read, write on
// clock edge). Sub-word stores use read-modify-write.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, we, funct3,      request handshake and descriptor (sampled in IDLE)
//   addr, wdata
//   busy                  high while not IDLE
//   done, err             one-cycle completion pulse, rejection flag
//   rdata                 extended load result, updated with done
//   mem_write, mem_addr,  memory write strobe, word address, write data
//   mem_wdata
//   mem_rdata             combinational memory read data for mem_addr
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  state_e      next_state;

  // Latched request. Only the bits the later states consume are kept: the
  // word address lives in mem_addr, and full-word store data goes straight
  // into mem_wdata on acceptance.
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        oor_s;
  logic        bad_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_s;

  assign oor_s = |addr[31:ADDR_WIDTH];
  assign bad_s = access_bad(we, funct3, addr[1:0], oor_s);

  // The memory word is consumed on the same edge it is captured (leaving
  // READ), so the lane logic works directly on mem_rdata.
  lsu_align u_align (
    .word       (mem_rdata),
    .lane       (lane_q),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data_s),
    .store_word (merge_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (bad_s) begin
            next_state = S_RESP;
          end else if (!we) begin
            next_state = S_READ;
          end else if (funct3 == F3_W) begin
            next_state = S_WRITE;
          end else begin
            next_state = S_READ;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_READ:  next_state = we_q ? S_WRITE : S_RESP;
      S_WRITE: next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs, registered from the next state so they align with it.
  // Only a rejected request goes straight from IDLE to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      busy      <= (next_state != S_IDLE);
      done      <= (next_state == S_RESP);
      err       <= (state == S_IDLE) && (next_state == S_RESP);
      mem_write <= (next_state == S_WRITE);
    end
  end

  // Request capture and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      lane_q    <= 2'b00;
      wdata_q   <= 16'h0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      rdata     <= 32'h0000_0000;
    end else begin
      if ((state == S_IDLE) && req) begin
        we_q     <= we;
        funct3_q <= funct3;
        lane_q   <= addr[1:0];
        wdata_q  <= wdata[15:0];
        mem_addr <= {addr[31:2], 2'b00};
      end
      // sw enters WRITE straight from IDLE with the raw store word;
      // sb/sh come from READ with the merged word.
      if (next_state == S_WRITE) begin
        mem_wdata <= (state == S_IDLE) ? wdata : merge_s;
      end
      if (next_state == S_RESP) begin
        rdata <= ((state == S_READ) && !we_q) ? load_data_s : 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized loads/stores compared against a transaction-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_val;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Data memory: combinational read, write on rising edge; preload port for the bench.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic preload(input int idx, input logic [31:0] val);
    pre_en  = 1'b1;
    pre_idx = idx[7:0];
    pre_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Transaction-level reference: size from funct3, alignment by modulo,
  // lane handled with byte masks and two's-complement arithmetic.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] rd,
                       output logic [31:0] nw, output int lat);
    int size;
    int idx;
    int off;
    logic [31:0] old;
    logic [31:0] raw;
    logic [31:0] v;
    logic [31:0] mask;
    rd = 32'h0; nw = 32'h0; lat = 1;
    if (w) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    else   size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 :
                  (f3 == 3'd2) ? 4 : 0;
    e = (size == 0) || (a >= 32'd1024) || ((a % size) != 0);
    if (e) return;
    idx = int'(a / 4);
    off = int'(a % 4);
    old = ref_mem[idx];
    if (!w) begin
      lat = 2;
      raw = old >> (8 * off);
      if (size == 1) begin
        v = raw & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2) begin
        v = raw & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end else begin
        v = old;
      end
      rd = v;
    end else begin
      lat  = (size == 4) ? 2 : 3;
      mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * size)) - 32'd1) << (8 * off));
      nw   = (old & ~mask) | ((d << (8 * off)) & mask);
      ref_mem[idx] = nw;
    end
  endtask

  // Drive one request at a negedge and follow it to completion.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input bit toggle,
                        output logic [31:0] got_rd, output logic [31:0] got_wd);
    logic        e;
    logic [31:0] erd;
    logic [31:0] enw;
    int          lat;
    int          cyc;
    int          nwr;
    bit          seen;
    logic        got_err;
    model(w, f3, a, d, e, erd, enw, lat);
    we = w; funct3 = f3; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    cyc = 0; nwr = 0; seen = 1'b0; got_rd = 32'h0; got_wd = 32'h0; got_err = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      check_eq("busy_during", {31'h0, busy}, 32'h1);
      if (!e) check_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (mem_write) begin
        nwr++;
        got_wd = mem_wdata;
      end
      if (done) begin
        seen    = 1'b1;
        got_rd  = rdata;
        got_err = err;
      end
      if (toggle && !seen) begin
        req    = 1'($urandom % 2);
        we     = 1'($urandom % 2);
        funct3 = 3'($urandom % 8);
        addr   = $urandom;
        wdata  = $urandom;
      end else begin
        req = 1'b0;
      end
    end
    check_eq("done_seen", {31'h0, seen}, 32'h1);
    check_eq("latency", cyc, lat);
    check_eq("err", {31'h0, got_err}, {31'h0, e});
    check_eq("rdata", got_rd, erd);
    check_eq("n_write", nwr, (!e && w) ? 1 : 0);
    if (w && !e) check_eq("mem_wdata", got_wd, enw);
    @(negedge clk);
    check_eq("idle_after", {29'h0, busy, done, mem_write}, 32'h0);
    check_eq("rdata_held", rdata, erd);
    if (w && !e) check_eq("mem_content", mem[a[9:2]], ref_mem[a[9:2]]);
  endtask

  logic [31:0] r;
  logic [31:0] wd;

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ctrl", {28'h0, busy, done, err, mem_write}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    preload(4, 32'hDEAD_BEEF);
    run_op(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, r, wd);
    check_eq("lw_dir", r, 32'hDEAD_BEEF);
    preload(4, 32'h80FF_0000);
    run_op(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, r, wd);
    check_eq("lb_dir", r, 32'hFFFF_FF80);
    run_op(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, r, wd);
    check_eq("lbu_dir", r, 32'h0000_0080);
    preload(4, 32'h1122_3344);
    run_op(1'b1, 3'd0, 32'h11, 32'h5555_55AA, 1'b0, r, wd);
    check_eq("sb_dir", wd, 32'h1122_AA44);
    run_op(1'b1, 3'd1, 32'h12, 32'h7777_BEEF, 1'b0, r, wd);
    check_eq("sh_dir", wd, 32'hBEEF_AA44);
    run_op(1'b0, 3'd1, 32'h01, 32'h0, 1'b0, r, wd);
    run_op(1'b1, 3'd2, 32'h02, 32'h1234_5678, 1'b0, r, wd);
    run_op(1'b0, 3'd3, 32'h00, 32'h0, 1'b0, r, wd);
    run_op(1'b0, 3'd2, 32'h400, 32'h0, 1'b0, r, wd);
    check_eq("oor_rdata", r, 32'h0);
    run_op(1'b1, 3'd0, 32'h2D, 32'h0000_0066, 1'b1, r, wd);
    run_op(1'b0, 3'd2, 32'h2C, 32'h0, 1'b0, r, wd);
    run_op(1'b0, 3'd2, 32'h2C, 32'h0, 1'b0, r, wd);

    // Reset asserted during the WRITE cycle of an sh.
    preload(8, 32'h0BAD_F00D);
    we = 1'b1; funct3 = 3'd1; addr = 32'h22; wdata = 32'h0000_CAFE; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check_eq("wr_before_rst", {31'h0, mem_write}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check_eq("wr_async_drop", {29'h0, mem_write, busy, done}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_done_rst", {31'h0, done}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("no_done_after", {31'h0, done}, 32'h0);
    run_op(1'b0, 3'd2, 32'h20, 32'h0, 1'b0, r, wd);
    check_eq("lw_after_rst", r, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic        rw;
      logic [2:0]  rf;
      logic [31:0] ra;
      rw = 1'($urandom % 2);
      rf = 3'($urandom % 8);
      ra = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if ($urandom % 2 == 0) ra[1:0] = 2'b00;
      run_op(rw, rf, ra, $urandom, 1'($urandom % 4 == 0), r, wd);
      for (int g = 0; g < int'($urandom % 3); g++) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
